// File: rtl/conv_loop_sequencer.sv
// Loop-nest sequencer for binary convolution: emits one (oci, ico, wj, wi, j, i)
// index tuple per accepted beat, flags the last beat of each output pixel, pulses done at layer end.
module conv_loop_sequencer #(
    parameter int unsigned KS = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] iw_i,
    input  logic [31:0] ih_i,
    input  logic [31:0] ic_i,
    input  logic [31:0] oc_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] oci_o,
    output logic [31:0] ico_o,
    output logic [31:0] wj_o,
    output logic [31:0] wi_o,
    output logic [31:0] j_o,
    output logic [31:0] i_o,
    output logic        acc_last_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);

    localparam logic [31:0] KS_W  = 32'(KS);
    localparam logic [31:0] KS_M1 = 32'(KS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_ow, r_oh, r_icw, r_oc;
    logic        r_err;
    logic [31:0] r_oci, r_ico, r_wj, r_wi, r_j, r_i;

    logic w_cfg_bad, w_fire;
    logic w_wi_max, w_wj_max, w_ico_max, w_i_max, w_j_max, w_oci_max, w_last;

    assign w_cfg_bad = (iw_i < KS_W) || (ih_i < KS_W) || (ic_i < 32'd32) || (oc_i == '0);
    assign w_fire    = (r_state == ST_RUN) && ready_i;

    assign w_wi_max  = (r_wi  == KS_M1);
    assign w_wj_max  = (r_wj  == KS_M1);
    assign w_ico_max = (r_ico == r_icw - 32'd1);
    assign w_i_max   = (r_i   == r_ow  - 32'd1);
    assign w_j_max   = (r_j   == r_oh  - 32'd1);
    assign w_oci_max = (r_oci == r_oc  - 32'd1);
    assign w_last    = w_wi_max && w_wj_max && w_ico_max && w_i_max && w_j_max && w_oci_max;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start_i) w_next = w_cfg_bad ? ST_DONE : ST_RUN;
            ST_RUN:  if (w_fire && w_last) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_ow    <= '0;
            r_oh    <= '0;
            r_icw   <= '0;
            r_oc    <= '0;
            r_err   <= 1'b0;
            r_oci   <= '0;
            r_ico   <= '0;
            r_wj    <= '0;
            r_wi    <= '0;
            r_j     <= '0;
            r_i     <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == ST_IDLE) && start_i) begin
                r_ow  <= iw_i - KS_W + 32'd1;
                r_oh  <= ih_i - KS_W + 32'd1;
                r_icw <= {5'd0, ic_i[31:5]};
                r_oc  <= oc_i;
                r_err <= w_cfg_bad;
            end
            // Odometer: each level wraps and carries only when every inner level wraps;
            // the final handshake wraps all six, leaving the counters at zero.
            if (w_fire) begin
                r_wi <= w_wi_max ? '0 : r_wi + 32'd1;
                if (w_wi_max) begin
                    r_wj <= w_wj_max ? '0 : r_wj + 32'd1;
                    if (w_wj_max) begin
                        r_ico <= w_ico_max ? '0 : r_ico + 32'd1;
                        if (w_ico_max) begin
                            r_i <= w_i_max ? '0 : r_i + 32'd1;
                            if (w_i_max) begin
                                r_j <= w_j_max ? '0 : r_j + 32'd1;
                                if (w_j_max) begin
                                    r_oci <= w_oci_max ? '0 : r_oci + 32'd1;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    assign valid_o    = (r_state == ST_RUN);
    assign busy_o     = (r_state == ST_RUN);
    assign done_o     = (r_state == ST_DONE);
    assign error_o    = (r_state == ST_DONE) && r_err;
    assign acc_last_o = (r_state == ST_RUN) && w_ico_max && w_wj_max && w_wi_max;
    assign oci_o      = r_oci;
    assign ico_o      = r_ico;
    assign wj_o       = r_wj;
    assign wi_o       = r_wi;
    assign j_o        = r_j;
    assign i_o        = r_i;

endmodule

// File: tb/tb_conv_loop_sequencer.sv
// Directed self-checking bench for conv_loop_sequencer: expected tuples come from a
// mixed-radix decomposition of the beat number, cross-checked with hand-computed beats.
module tb_conv_loop_sequencer;

    localparam int unsigned KS = 3;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] iw_i = '0, ih_i = '0, ic_i = '0, oc_i = '0;
    logic        ready_i = 1'b1;
    logic        valid_o, acc_last_o, busy_o, done_o, error_o;
    logic [31:0] oci_o, ico_o, wj_o, wi_o, j_o, i_o;

    conv_loop_sequencer #(.KS(KS)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .iw_i(iw_i), .ih_i(ih_i), .ic_i(ic_i), .oc_i(oc_i),
        .ready_i(ready_i), .valid_o(valid_o),
        .oci_o(oci_o), .ico_o(ico_o), .wj_o(wj_o), .wi_o(wi_o), .j_o(j_o), .i_o(i_o),
        .acc_last_o(acc_last_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] oci, ico, wj, wi, j, i;
    } tuple_t;

    int     checks = 0;
    int     errors = 0;
    tuple_t obs[0:255];
    logic   obs_last[0:255];
    int     obs_cyc[0:255];
    int     nbeats, done_cyc, hold_bad;
    logic   done_err;

    function automatic tuple_t exp_tuple(input int unsigned beat, input int unsigned ow,
                                         input int unsigned oh, input int unsigned icw);
        tuple_t      t;
        int unsigned k;
        k = beat;
        t.wi  = k % KS;  k = k / KS;
        t.wj  = k % KS;  k = k / KS;
        t.ico = k % icw; k = k / icw;
        t.i   = k % ow;  k = k / ow;
        t.j   = k % oh;  k = k / oh;
        t.oci = k;
        return t;
    endfunction

    function automatic tuple_t cur_tuple();
        return {oci_o, ico_o, wj_o, wi_o, j_o, i_o};
    endfunction

    task automatic start_layer(input logic [31:0] iw, input logic [31:0] ih,
                               input logic [31:0] ic, input logic [31:0] oc);
        @(negedge clk_i);
        iw_i = iw; ih_i = ih; ic_i = ic; oc_i = oc;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    // Drives ready_i and records every accepted tuple until done_o, with a cycle budget.
    task automatic run_layer(input bit stall);
        tuple_t prev;
        logic   prev_last;
        bit     prev_stall;
        bit     rdy;
        prev = '0; prev_last = 1'b0; prev_stall = 1'b0;
        nbeats = 0; done_cyc = -1; hold_bad = 0; done_err = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (done_o) begin
                done_cyc = cyc;
                done_err = error_o;
                break;
            end
            if (valid_o) begin
                if (prev_stall && ((cur_tuple() !== prev) || (acc_last_o !== prev_last)))
                    hold_bad++;
                rdy = stall ? (($urandom_range(0, 3) != 0) && ((cyc % 4) != 2)) : 1'b1;
                ready_i = rdy;
                if (rdy && nbeats < 256) begin
                    obs[nbeats]      = cur_tuple();
                    obs_last[nbeats] = acc_last_o;
                    obs_cyc[nbeats]  = cyc;
                    nbeats++;
                end
                prev_stall = !rdy;
                prev       = cur_tuple();
                prev_last  = acc_last_o;
            end
            @(negedge clk_i);
        end
        ready_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b1; iw_i = 4; ih_i = 4; ic_i = 32; oc_i = 1;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({valid_o, busy_o, done_o, error_o, acc_last_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000", {valid_o, busy_o, done_o, error_o, acc_last_o});
        end
        start_i = 1'b0; rst_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (cur_tuple() !== '0 || valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got tuple %h valid %b busy %b expected zeros", cur_tuple(), valid_o, busy_o);
        end
    endtask

    task automatic test_basic();
        tuple_t t9;
        int     nlast;
        start_layer(4, 4, 32, 1);
        run_layer(1'b0);
        checks++;
        if (nbeats != 36) begin errors++; $display("FAIL basic_beats: got %0d expected 36", nbeats); end
        checks++;
        if (done_cyc != 36) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 36", done_cyc); end
        checks++;
        if (done_err !== 1'b0) begin errors++; $display("FAIL basic_error: got %b expected 0", done_err); end
        nlast = 0;
        for (int k = 0; k < nbeats && k < 36; k++) begin
            checks++;
            if (obs[k] !== exp_tuple(k, 2, 2, 1) || obs_cyc[k] != k || obs_last[k] !== ((k % 9) == 8)) begin
                errors++;
                $display("FAIL basic_beat%0d: got %h last %b cyc %0d expected %h last %b cyc %0d",
                         k, obs[k], obs_last[k], obs_cyc[k], exp_tuple(k, 2, 2, 1), (k % 9) == 8, k);
            end
            if (obs_last[k] === 1'b1) nlast++;
        end
        t9 = '0; t9.i = 1;
        checks++;
        if (obs[0] !== '0 || obs[9] !== t9) begin
            errors++;
            $display("FAIL basic_beats_0_9: got %h / %h expected %h / %h", obs[0], obs[9], 192'd0, t9);
        end
        checks++;
        if (nlast != 4) begin errors++; $display("FAIL basic_acc_last_count: got %0d expected 4", nlast); end
        @(negedge clk_i);
        checks++;
        if ({done_o, valid_o, busy_o} !== 3'b000 || cur_tuple() !== '0) begin
            errors++;
            $display("FAIL basic_after_done: got done %b valid %b busy %b tuple %h expected 0s",
                     done_o, valid_o, busy_o, cur_tuple());
        end
    endtask

    task automatic test_channels();
        tuple_t t18;
        start_layer(3, 3, 64, 2);
        run_layer(1'b0);
        checks++;
        if (nbeats != 36 || done_cyc != 36) begin
            errors++;
            $display("FAIL chan_beats: got %0d beats done@%0d expected 36 done@36", nbeats, done_cyc);
        end
        for (int k = 0; k < nbeats && k < 36; k++) begin
            checks++;
            if (obs[k] !== exp_tuple(k, 1, 1, 2) || obs_last[k] !== ((k % 18) == 17)) begin
                errors++;
                $display("FAIL chan_beat%0d: got %h last %b expected %h last %b",
                         k, obs[k], obs_last[k], exp_tuple(k, 1, 1, 2), (k % 18) == 17);
            end
        end
        t18 = '0; t18.oci = 1;
        checks++;
        if (obs[9].ico !== 32'd1 || obs[18] !== t18) begin
            errors++;
            $display("FAIL chan_beats_9_18: got ico %0d / %h expected 1 / %h", obs[9].ico, obs[18], t18);
        end
    endtask

    task automatic test_stall();
        start_layer(4, 4, 32, 1);
        run_layer(1'b1);
        checks++;
        if (nbeats != 36 || done_cyc <= 36) begin
            errors++;
            $display("FAIL stall_beats: got %0d beats done@%0d expected 36 beats done after 36", nbeats, done_cyc);
        end
        checks++;
        if (hold_bad != 0) begin errors++; $display("FAIL stall_hold: got %0d changes expected 0", hold_bad); end
        for (int k = 0; k < nbeats && k < 36; k++) begin
            checks++;
            if (obs[k] !== exp_tuple(k, 2, 2, 1) || obs_last[k] !== ((k % 9) == 8)) begin
                errors++;
                $display("FAIL stall_beat%0d: got %h expected %h", k, obs[k], exp_tuple(k, 2, 2, 1));
            end
        end
    endtask

    task automatic test_bad_config();
        logic [31:0] cfg[4][4];
        cfg[0] = '{32'd2, 32'd4, 32'd32, 32'd1};
        cfg[1] = '{32'd4, 32'd2, 32'd32, 32'd1};
        cfg[2] = '{32'd4, 32'd4, 32'd31, 32'd1};
        cfg[3] = '{32'd4, 32'd4, 32'd32, 32'd0};
        for (int n = 0; n < 4; n++) begin
            start_layer(cfg[n][0], cfg[n][1], cfg[n][2], cfg[n][3]);
            checks++;
            if ({done_o, error_o, valid_o, busy_o} !== 4'b1100) begin
                errors++;
                $display("FAIL bad_cfg%0d_done: got done/err/valid/busy %b expected 1100",
                         n, {done_o, error_o, valid_o, busy_o});
            end
            @(negedge clk_i);
            checks++;
            if ({done_o, error_o, valid_o, busy_o} !== 4'b0000) begin
                errors++;
                $display("FAIL bad_cfg%0d_idle: got done/err/valid/busy %b expected 0000",
                         n, {done_o, error_o, valid_o, busy_o});
            end
        end
    endtask

    task automatic test_midrun_start_and_reset();
        bit stray;
        start_layer(4, 4, 32, 1);
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (valid_o !== 1'b1 || cur_tuple() !== exp_tuple(k, 2, 2, 1)) begin
                errors++;
                $display("FAIL midrun_beat%0d: got valid %b %h expected 1 %h", k, valid_o, cur_tuple(), exp_tuple(k, 2, 2, 1));
            end
            start_i = (k == 5);
            iw_i = (k == 5) ? 32'd8 : 32'd4;
            @(negedge clk_i);
        end
        start_i = 1'b0; iw_i = 4;
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        checks++;
        if ({valid_o, busy_o, done_o, error_o, acc_last_o} !== 5'b0 || cur_tuple() !== '0) begin
            errors++;
            $display("FAIL midrun_reset: got flags %b tuple %h expected zeros",
                     {valid_o, busy_o, done_o, error_o, acc_last_o}, cur_tuple());
        end
        stray = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            if (done_o || valid_o) stray = 1'b1;
        end
        checks++;
        if (stray) begin errors++; $display("FAIL midrun_no_done: got activity after reset expected none"); end
        start_layer(4, 4, 32, 1);
        run_layer(1'b0);
        checks++;
        if (nbeats != 36 || done_cyc != 36) begin
            errors++;
            $display("FAIL restart_beats: got %0d beats done@%0d expected 36 done@36", nbeats, done_cyc);
        end
        for (int k = 0; k < nbeats && k < 36; k++) begin
            checks++;
            if (obs[k] !== exp_tuple(k, 2, 2, 1)) begin
                errors++;
                $display("FAIL restart_beat%0d: got %h expected %h", k, obs[k], exp_tuple(k, 2, 2, 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_channels();
        test_stall();
        test_bad_config();
        test_midrun_start_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
